// File: rtl/quad_and2_gate_if.sv
// Signal bundle for the quad 2-input AND package: gate inputs, combinational
// outputs and the synchronous observation outputs.
interface quad_and2_gate_if #(
    parameter int CNT_W = 16
);
    logic             A1;
    logic             B1;
    logic             A2;
    logic             B2;
    logic             A3;
    logic             B3;
    logic             A4;
    logic             B4;
    logic             Y1;
    logic             Y2;
    logic             Y3;
    logic             Y4;
    logic [3:0]       y_q;
    logic [3:0]       rise;
    logic [CNT_W-1:0] act_cnt;

    modport master (
        output A1, B1, A2, B2, A3, B3, A4, B4,
        input  Y1, Y2, Y3, Y4, y_q, rise, act_cnt
    );

    modport slave (
        input  A1, B1, A2, B2, A3, B3, A4, B4,
        output Y1, Y2, Y3, Y4, y_q, rise, act_cnt
    );
endinterface

// File: rtl/quad_and2_gate.sv
// 74x08 quad AND model: four zero-latency gates plus a registered copy,
// per-gate rising-edge flags and a saturating rising-edge counter.
module quad_and2_gate #(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    quad_and2_gate_if.slave      bus
);
    logic [3:0]       a_vec;
    logic [3:0]       b_vec;
    logic [3:0]       y_comb;
    logic [3:0]       yreg_q;
    logic [3:0]       yreg_d;
    logic [3:0]       rise_q;
    logic [3:0]       rise_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]       pop;
    logic [CNT_W:0]   sum;

    localparam logic [CNT_W-1:0] SAT_MAX = {CNT_W{1'b1}};

    assign a_vec = {bus.A4, bus.A3, bus.A2, bus.A1};
    assign b_vec = {bus.B4, bus.B3, bus.B2, bus.B1};

    // Plain AND keeps the 0&X=0 / 1&X=X behaviour of the physical part.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_gate
            assign y_comb[gi] = a_vec[gi] & b_vec[gi];
            assign rise_d[gi] = y_comb[gi] & ~yreg_q[gi];
        end
    endgenerate

    assign yreg_d = y_comb;

    always_comb begin
        pop = 3'd0;
        for (int i = 0; i < 4; i++) begin
            pop = pop + {2'b00, rise_d[i]};
        end
        sum   = {1'b0, cnt_q} + (CNT_W + 1)'(pop);
        cnt_d = (sum > {1'b0, SAT_MAX}) ? SAT_MAX : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            yreg_q <= 4'd0;
            rise_q <= 4'd0;
            cnt_q  <= '0;
        end else begin
            yreg_q <= yreg_d;
            rise_q <= rise_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.Y1      = y_comb[0];
    assign bus.Y2      = y_comb[1];
    assign bus.Y3      = y_comb[2];
    assign bus.Y4      = y_comb[3];
    assign bus.y_q     = yreg_q;
    assign bus.rise    = rise_q;
    assign bus.act_cnt = cnt_q;
endmodule

// File: tb/tb_quad_and2_gate.sv
// Randomised and directed bench for quad_and2_gate with a queue-based
// scoreboard; a 16-bit and a 4-bit counter instance share the same inputs.
module tb_quad_and2_gate;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] a = 4'd0;
    logic [3:0] b = 4'd0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] y;
        logic [3:0] rise;
        int         cnt16;
        int         cnt4;
    } exp_t;

    exp_t exp_q[$];

    // Reference state
    logic [3:0] m_prev = 4'd0;
    int         m_cnt16 = 0;
    int         m_cnt4  = 0;

    always #5 clk = ~clk;

    quad_and2_gate_if #(.CNT_W(16)) bus16 ();
    quad_and2_gate_if #(.CNT_W(4))  bus4 ();

    assign bus16.A1 = a[0]; assign bus16.B1 = b[0];
    assign bus16.A2 = a[1]; assign bus16.B2 = b[1];
    assign bus16.A3 = a[2]; assign bus16.B3 = b[2];
    assign bus16.A4 = a[3]; assign bus16.B4 = b[3];
    assign bus4.A1  = a[0]; assign bus4.B1  = b[0];
    assign bus4.A2  = a[1]; assign bus4.B2  = b[1];
    assign bus4.A3  = a[2]; assign bus4.B3  = b[2];
    assign bus4.A4  = a[3]; assign bus4.B4  = b[3];

    quad_and2_gate #(.CNT_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));
    quad_and2_gate #(.CNT_W(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // One stimulus cycle: drive, check the combinational gates, queue the
    // registered outcome of the coming edge.
    task automatic drive(input logic [3:0] av, input logic [3:0] bv, input logic rv);
        exp_t e;
        int   nrise;
        @(negedge clk);
        a     = av;
        b     = bv;
        rst_n = rv;
        if (!rv) begin
            m_prev  = 4'd0;
            e.rise  = 4'd0;
            m_cnt16 = 0;
            m_cnt4  = 0;
        end else begin
            nrise = 0;
            for (int n = 0; n < 4; n++) begin
                e.rise[n] = (av[n] && bv[n]) && !m_prev[n];
                if (e.rise[n]) nrise++;
            end
            m_prev  = av & bv;
            m_cnt16 = (m_cnt16 + nrise > 65535) ? 65535 : m_cnt16 + nrise;
            m_cnt4  = (m_cnt4 + nrise > 15) ? 15 : m_cnt4 + nrise;
        end
        e.y     = m_prev;
        e.cnt16 = m_cnt16;
        e.cnt4  = m_cnt4;
        exp_q.push_back(e);
        #1;
        check("Y", int'({bus16.Y4, bus16.Y3, bus16.Y2, bus16.Y1}), int'(av & bv));
        $display("drive a=%b b=%b rst_n=%b exp_y_q=%b exp_rise=%b exp_cnt=%0d/%0d",
                 av, bv, rv, e.y, e.rise, e.cnt16, e.cnt4);
    endtask

    // Monitor: the DUT presents fresh registered outputs after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("y_q",       int'(bus16.y_q),     int'(e.y));
                check("rise",      int'(bus16.rise),    int'(e.rise));
                check("act_cnt16", int'(bus16.act_cnt), e.cnt16);
                check("rise_w4",   int'(bus4.rise),     int'(e.rise));
                check("act_cnt4",  int'(bus4.act_cnt),  e.cnt4);
            end
        end
    end

    initial begin
        logic [1:0] pat [4];
        pat[0] = 2'b11; pat[1] = 2'b01; pat[2] = 2'b10; pat[3] = 2'b00;

        // Initial reset with random inputs
        repeat (2) drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);

        // Each gate exhaustively, others held low
        for (int g = 0; g < 4; g++) begin
            for (int p = 0; p < 4; p++) begin
                logic [3:0] av, bv;
                av = 4'd0; bv = 4'd0;
                av[g] = pat[p][1];
                bv[g] = pat[p][0];
                repeat (2) drive(av, bv, 1'b1);
            end
        end

        // All gates high together
        repeat (3) drive(4'hF, 4'hF, 1'b1);

        // Reset priority with toggling inputs, then release with gate 1 high
        drive(4'($urandom_range(0, 15)), 4'hF, 1'b0);
        drive(4'($urandom_range(0, 15)), 4'hF, 1'b0);
        drive(4'b0001, 4'b0001, 1'b1);
        drive(4'b0001, 4'b0001, 1'b1);

        // Single-gate edge count on gate 2
        drive(4'b0000, 4'b0000, 1'b0);
        drive(4'b0000, 4'b0010, 1'b1);
        drive(4'b0010, 4'b0010, 1'b1);
        drive(4'b0000, 4'b0010, 1'b1);
        drive(4'b0010, 4'b0010, 1'b1);
        drive(4'b0000, 4'b0010, 1'b1);
        drive(4'b0000, 4'b0010, 1'b1);

        // Saturation: all gates toggling every other cycle
        for (int i = 0; i < 24; i++) begin
            logic [3:0] v;
            v = (i % 2 == 0) ? 4'hF : 4'h0;
            drive(v, 4'hF, 1'b1);
        end

        // Random traffic with occasional reset
        for (int i = 0; i < 300; i++) begin
            drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 29) != 0));
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/quad_and2_gate.md
Name: quad_and2_gate

Overview:
- Behavioural model of a 74x08 quad 2-input AND package, used as a glue-logic primitive in the 74xx component library.
- Four independent gates produce Yn = An & Bn combinationally, with zero latency, exactly like the physical chip.
- Adds a synchronous observation layer for system-level benches:
  - registered copies of the four outputs;
  - per-gate rising-edge flags;
  - a saturating activity counter.

Parameters:
- CNT_W, default 16: width of the activity counter act_cnt; legal range 4..32.

Ports:
- clk  input  1  system clock; all registered state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- A1  input  1  gate 1 input A.
- B1  input  1  gate 1 input B.
- A2  input  1  gate 2 input A.
- B2  input  1  gate 2 input B.
- A3  input  1  gate 3 input A.
- B3  input  1  gate 3 input B.
- A4  input  1  gate 4 input A.
- B4  input  1  gate 4 input B.
- Y1  output  1  A1 & B1, combinational.
- Y2  output  1  A2 & B2, combinational.
- Y3  output  1  A3 & B3, combinational.
- Y4  output  1  A4 & B4, combinational.
- y_q  output  4  registered {Y4,Y3,Y2,Y1}.
- rise  output  4  one-cycle pulse per gate when its output went 0->1.
- act_cnt  output  CNT_W  saturating count of gate-output rising edges.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n. No asynchronous reset path exists.
- Y1..Y4 combinational logic:
  - Pure AND of the matching A/B pair, with no clock involvement.
  - Not affected by rst_n; valid during and after reset.
  - Gates are fully independent; changing one pair never disturbs another output.
- Truth table per gate: 00->0, 01->0, 10->0, 11->1.
- X/Z propagation: 0 & X = 0; 1 & X = X.
- Registered copy:
  - Each rising clk edge with rst_n=1: y_q <= {Y4,Y3,Y2,Y1}.
  - Latency is 1 cycle from an input change to y_q.
- Rising-edge flags:
  - rise[n] = 1 for exactly one cycle when the newly sampled Yn=1 and the previous y_q[n]=0.
  - rise is registered and asserts in the same cycle y_q updates.
- Activity counter:
  - Each cycle, act_cnt increases by popcount(rise_next), where rise_next is the value rise takes at that edge.
  - Up to 4 is added per cycle.
  - Saturates at 2^CNT_W-1 and never wraps; once saturated it holds until reset.
- Reset:
  - rst_n=0 at a rising edge forces y_q=0, rise=0, act_cnt=0.
  - The first edge after reset release compares against y_q=0, so a gate already high at release pulses rise once.
  - Reset mid-operation discards any pending edge with no partial count.
- Power-up: registered outputs are undefined until the first reset edge; Y1..Y4 are valid immediately.

Test Plan:
- Gate 1 exhaustive: apply (A1,B1) = 11, 01, 10, 00, holding each 20 time units -> Y1 = 1, 0, 0, 0; Y2..Y4 unchanged.
- Gates 2, 3, 4 exhaustive: same four-step sequence on each pair in turn -> Yn = 1, 0, 0, 0; other outputs unaffected.
- All gates together: inputs 11 on all four, clk running with rst_n=1:
  - Y=1111 immediately;
  - y_q=4'hF and rise=4'hF after one edge, rise=0 the next cycle;
  - act_cnt = 4.
- Reset priority: hold rst_n=0 for 2 edges while toggling inputs:
  - Y follows the AND function;
  - y_q, rise and act_cnt stay 0;
  - on release with A1=B1=1, the first edge gives rise=4'b0001 and act_cnt=1.
- Saturation: CNT_W=4, toggle all four gates every other cycle -> act_cnt reaches 15 and holds at 15 with no wrap.
- Single-gate edge count: toggle A2 0->1->0->1 with B2=1 over 6 cycles -> two rise[1] pulses, act_cnt=2, other rise bits 0.
